// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------------------------------------------------------------------
// Shares the single Sysbus memory port between two cache clients
// (client 0 = instruction cache, client 1 = data cache). A client owns the
// bus for one whole transaction:
//   read : address beat, then BEATS response beats
//   write: address beat, then BEATS write-data beats
// Contended grants alternate round-robin. While a grant is held every
// handshake is a combinational pass-through, so there is no added per-beat
// latency.
//
// Handshake rule (all channels): a beat transfers on a rising clk edge where
// the producer's *cyc and the consumer's *ack are both high. A producer holds
// its beat stable until that edge. Stalls of any length are allowed.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   cN_bus_reqcyc/req/reqtag  in   client N request/write-data beat
//   cN_bus_reqack             out  beat accepted (owner only)
//   cN_bus_respcyc/resp/resptag out response beat (owner, reads only)
//   cN_bus_respack            in   client accepted response beat
//   m_bus_reqcyc/req/reqtag   out  request/write-data beat to memory
//   m_bus_reqack              in   memory accepted beat
//   m_bus_respcyc/resp/resptag in  response beat from memory
//   m_bus_respack             out  response accepted (owner's respack)
//   dbg_state, dbg_owner, dbg_is_write  out  FSM state for observation
// ---------------------------------------------------------------------------

// Normally provided by Sysbus.defs; the fallback keeps this file standalone.
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b1
`endif

module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    // client 0 (instruction cache)
    input  logic                      c0_bus_reqcyc,
    output logic                      c0_bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] c0_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c0_bus_reqtag,
    output logic                      c0_bus_respcyc,
    input  logic                      c0_bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] c0_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c0_bus_resptag,
    // client 1 (data cache)
    input  logic                      c1_bus_reqcyc,
    output logic                      c1_bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] c1_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c1_bus_reqtag,
    output logic                      c1_bus_respcyc,
    input  logic                      c1_bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] c1_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c1_bus_resptag,
    // memory side
    output logic                      m_bus_reqcyc,
    input  logic                      m_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic                      m_bus_respcyc,
    output logic                      m_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,
    // debug
    output logic [1:0]                dbg_state,
    output logic                      dbg_owner,
    output logic                      dbg_is_write
);

    localparam int               CNT_W     = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic             is_write_q, is_write_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Signals of whichever client currently owns the bus.
    logic                      sel_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] sel_req;
    logic [BUS_TAG_WIDTH-1:0]  sel_reqtag;
    logic                      sel_respack;

    assign sel_reqcyc  = owner_q ? c1_bus_reqcyc  : c0_bus_reqcyc;
    assign sel_req     = owner_q ? c1_bus_req     : c0_bus_req;
    assign sel_reqtag  = owner_q ? c1_bus_reqtag  : c0_bus_reqtag;
    assign sel_respack = owner_q ? c1_bus_respack : c0_bus_respack;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;  // first contended grant goes to client 0
            is_write_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            is_write_q   <= is_write_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        is_write_d   = is_write_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (c0_bus_reqcyc || c1_bus_reqcyc) begin
                    if (c0_bus_reqcyc && c1_bus_reqcyc) begin
                        owner_d = ~last_grant_q;
                    end else begin
                        owner_d = c1_bus_reqcyc;
                    end
                    last_grant_d = owner_d;
                    cnt_d        = '0;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (!sel_reqcyc) begin
                    // Owner withdrew before the address was taken: drop the grant.
                    state_d = IDLE;
                end else if (m_bus_reqack) begin
                    is_write_d = (sel_reqtag[BUS_TAG_WIDTH-1] == `SYSBUS_WRITE);
                    state_d    = is_write_d ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (sel_reqcyc && m_bus_reqack) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RDATA: begin
                if (m_bus_respcyc && sel_respack) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: everything defaults to 0 so the non-owner and all idle
    // paths are quiet; the owner's paths are wired straight through.
    always_comb begin
        c0_bus_reqack  = 1'b0;
        c0_bus_respcyc = 1'b0;
        c0_bus_resp    = '0;
        c0_bus_resptag = '0;
        c1_bus_reqack  = 1'b0;
        c1_bus_respcyc = 1'b0;
        c1_bus_resp    = '0;
        c1_bus_resptag = '0;
        m_bus_reqcyc   = 1'b0;
        m_bus_req      = '0;
        m_bus_reqtag   = '0;
        m_bus_respack  = 1'b0;
        case (state_q)
            ADDR, WDATA: begin
                m_bus_reqcyc = sel_reqcyc;
                m_bus_req    = sel_req;
                m_bus_reqtag = sel_reqtag;
                if (owner_q) begin
                    c1_bus_reqack = m_bus_reqack;
                end else begin
                    c0_bus_reqack = m_bus_reqack;
                end
            end
            RDATA: begin
                m_bus_respack = sel_respack;
                if (owner_q) begin
                    c1_bus_respcyc = m_bus_respcyc;
                    c1_bus_resp    = m_bus_resp;
                    c1_bus_resptag = m_bus_resptag;
                end else begin
                    c0_bus_respcyc = m_bus_respcyc;
                    c0_bus_resp    = m_bus_resp;
                    c0_bus_resptag = m_bus_resptag;
                end
            end
            default: ;
        endcase
    end

    assign dbg_state    = state_q;
    assign dbg_owner    = owner_q;
    assign dbg_is_write = is_write_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: reset checks, a table of per-cycle vectors
// (write burst, stray response, abort), hand-written read/contention/reset
// sequences, and randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int BEATS = 8;
  localparam logic WR  = 1'b1;  // value of SYSBUS_WRITE

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          c0_bus_reqcyc, c0_bus_reqack, c0_bus_respcyc, c0_bus_respack;
  logic [DW-1:0] c0_bus_req, c0_bus_resp;
  logic [TW-1:0] c0_bus_reqtag, c0_bus_resptag;
  logic          c1_bus_reqcyc, c1_bus_reqack, c1_bus_respcyc, c1_bus_respack;
  logic [DW-1:0] c1_bus_req, c1_bus_resp;
  logic [TW-1:0] c1_bus_reqtag, c1_bus_resptag;
  logic          m_bus_reqcyc, m_bus_reqack, m_bus_respcyc, m_bus_respack;
  logic [DW-1:0] m_bus_req, m_bus_resp;
  logic [TW-1:0] m_bus_reqtag, m_bus_resptag;
  logic [1:0]    dbg_state;
  logic          dbg_owner, dbg_is_write;

  mem_bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .c0_bus_reqcyc(c0_bus_reqcyc), .c0_bus_reqack(c0_bus_reqack),
    .c0_bus_req(c0_bus_req), .c0_bus_reqtag(c0_bus_reqtag),
    .c0_bus_respcyc(c0_bus_respcyc), .c0_bus_respack(c0_bus_respack),
    .c0_bus_resp(c0_bus_resp), .c0_bus_resptag(c0_bus_resptag),
    .c1_bus_reqcyc(c1_bus_reqcyc), .c1_bus_reqack(c1_bus_reqack),
    .c1_bus_req(c1_bus_req), .c1_bus_reqtag(c1_bus_reqtag),
    .c1_bus_respcyc(c1_bus_respcyc), .c1_bus_respack(c1_bus_respack),
    .c1_bus_resp(c1_bus_resp), .c1_bus_resptag(c1_bus_resptag),
    .m_bus_reqcyc(m_bus_reqcyc), .m_bus_reqack(m_bus_reqack),
    .m_bus_req(m_bus_req), .m_bus_reqtag(m_bus_reqtag),
    .m_bus_respcyc(m_bus_respcyc), .m_bus_respack(m_bus_respack),
    .m_bus_resp(m_bus_resp), .m_bus_resptag(m_bus_resptag),
    .dbg_state(dbg_state), .dbg_owner(dbg_owner), .dbg_is_write(dbg_is_write)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are
  // sampled one more unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    c0_bus_reqcyc = 0; c0_bus_req = '0; c0_bus_reqtag = '0; c0_bus_respack = 0;
    c1_bus_reqcyc = 0; c1_bus_req = '0; c1_bus_reqtag = '0; c1_bus_respack = 0;
    m_bus_reqack = 0; m_bus_respcyc = 0; m_bus_resp = '0; m_bus_resptag = '0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctl"}, {m_bus_reqcyc, m_bus_respack, c0_bus_reqack, c1_bus_reqack,
                         c0_bus_respcyc, c1_bus_respcyc, dbg_state, dbg_owner, dbg_is_write}, 64'h0);
    chk({name, "_m_req"}, m_bus_req, 64'h0);
    chk({name, "_resp"}, c0_bus_resp | c1_bus_resp, 64'h0);
    chk({name, "_tags"}, {m_bus_reqtag, c0_bus_resptag, c1_bus_resptag}, 64'h0);
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    tick();
    tick();
    reset = 0;
    settle();
    chk_zero("reset");
  endtask

  // Client n presents a read request for addr.
  task automatic request(input int n, input logic [63:0] addr);
    if (n == 0) begin
      c0_bus_reqcyc = 1; c0_bus_req = addr; c0_bus_reqtag = {1'b0, 12'h001};
    end else begin
      c1_bus_reqcyc = 1; c1_bus_req = addr; c1_bus_reqtag = {1'b0, 12'h002};
    end
  endtask

  // Called in the ADDR cycle: memory accepts the address beat of client n.
  task automatic grant_addr(input int n, input logic [63:0] addr);
    m_bus_reqack = 1;
    settle();
    chk("addr_m_reqcyc", m_bus_reqcyc, 1);
    chk("addr_m_req", m_bus_req, addr);
    chk("addr_m_reqtag", m_bus_reqtag, (n == 0) ? 64'h001 : 64'h002);
    chk("addr_own_reqack", (n == 0) ? c0_bus_reqack : c1_bus_reqack, 1);
    chk("addr_other_reqack", (n == 0) ? c1_bus_reqack : c0_bus_reqack, 0);
    tick();
    m_bus_reqack = 0;
    if (n == 0) c0_bus_reqcyc = 0; else c1_bus_reqcyc = 0;
  endtask

  // Memory streams beats 0x11, 0x22, ... to client n; the client withholds
  // respack for stall_len cycles when stall_at beats have been taken.
  task automatic read_burst(input int n, input int nbeats, input int stall_at, input int stall_len);
    int got = 0;
    int stalled = 0;
    int cyc = 0;
    logic ack;
    logic [63:0] exp_d;
    while (got < nbeats && cyc < 100) begin
      exp_d = 64'h11 * (got + 1);
      ack = !(got == stall_at && stalled < stall_len);
      m_bus_respcyc = 1;
      m_bus_resp = exp_d;
      m_bus_resptag = 13'h0A0 + 13'(n);
      if (n == 0) begin c0_bus_respack = ack; c1_bus_respack = 1; end
      else begin c1_bus_respack = ack; c0_bus_respack = 1; end
      settle();
      chk("rd_own_respcyc", (n == 0) ? c0_bus_respcyc : c1_bus_respcyc, 1);
      chk("rd_other_respcyc", (n == 0) ? c1_bus_respcyc : c0_bus_respcyc, 0);
      chk("rd_data", (n == 0) ? c0_bus_resp : c1_bus_resp, exp_d);
      chk("rd_tag", (n == 0) ? c0_bus_resptag : c1_bus_resptag, 64'h0A0 + 64'(n));
      chk("rd_m_respack", m_bus_respack, ack);
      chk("rd_m_reqcyc", m_bus_reqcyc, 0);
      chk("rd_other_reqack", (n == 0) ? c1_bus_reqack : c0_bus_reqack, 0);
      if (ack) got++; else stalled++;
      tick();
      cyc++;
    end
    chk("rd_beats_done", 64'(got), 64'(nbeats));
    m_bus_respcyc = 0;
    c0_bus_respack = 0;
    c1_bus_respack = 0;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic c0_rc, c1_rc, c1_w, m_ack, m_rc, c_rack;
    logic [63:0] c1_req;
    logic e_mrc, e_mrack, e_c0ack, e_c1ack, e_c0rc, e_c1rc;
    logic [63:0] e_mreq;
  } vec_t;

  function automatic vec_t mk(input logic c0_rc, c1_rc, c1_w, m_ack, m_rc, c_rack,
                              input logic [63:0] c1_req,
                              input logic e_mrc, e_mrack, e_c0ack, e_c1ack, e_c0rc, e_c1rc,
                              input logic [63:0] e_mreq);
    vec_t v;
    v.c0_rc = c0_rc; v.c1_rc = c1_rc; v.c1_w = c1_w; v.m_ack = m_ack;
    v.m_rc = m_rc; v.c_rack = c_rack; v.c1_req = c1_req;
    v.e_mrc = e_mrc; v.e_mrack = e_mrack; v.e_c0ack = e_c0ack; v.e_c1ack = e_c1ack;
    v.e_c0rc = e_c0rc; v.e_c1rc = e_c1rc; v.e_mreq = e_mreq;
    return v;
  endfunction

  task automatic run_table();
    vec_t vt[$];
    //                c0 c1 w  ak rc ra  c1_req        mrc mra a0 a1 r0 r1  m_req
    vt.push_back(mk(0, 0, 0, 0, 1, 1, 64'h0,      0, 0, 0, 0, 0, 0, 64'h0));     // stray resp in IDLE
    vt.push_back(mk(0, 1, 1, 0, 0, 0, 64'h2040,   0, 0, 0, 0, 0, 0, 64'h0));     // c1 write sampled
    vt.push_back(mk(0, 1, 1, 0, 0, 0, 64'h2040,   1, 0, 0, 0, 0, 0, 64'h2040));  // ADDR, memory stalls
    vt.push_back(mk(0, 1, 1, 1, 0, 0, 64'h2040,   1, 0, 0, 1, 0, 0, 64'h2040));  // address taken
    vt.push_back(mk(0, 1, 1, 0, 1, 1, 64'hA0,     1, 0, 0, 0, 0, 0, 64'hA0));    // data stall + stray resp
    for (int i = 0; i < BEATS; i++)
      vt.push_back(mk(0, 1, 1, 1, 0, 0, 64'hA0 + 64'(i), 1, 0, 0, 1, 0, 0, 64'hA0 + 64'(i)));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0,      0, 0, 0, 0, 0, 0, 64'h0));     // turnaround IDLE
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0,      1, 0, 0, 0, 0, 0, 64'h3000));  // c0 ADDR
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,      0, 0, 0, 0, 0, 0, 64'h3000));  // c0 withdraws
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,      0, 0, 0, 0, 0, 0, 64'h0));     // aborted to IDLE
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 64'h40,     0, 0, 0, 0, 0, 0, 64'h0));     // c1 read sampled
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 64'h40,     1, 0, 0, 0, 0, 0, 64'h40));    // c1 ADDR
    for (int i = 0; i < vt.size(); i++) begin
      c0_bus_reqcyc = vt[i].c0_rc; c0_bus_req = 64'h3000; c0_bus_reqtag = '0;
      c1_bus_reqcyc = vt[i].c1_rc; c1_bus_req = vt[i].c1_req;
      c1_bus_reqtag = {vt[i].c1_w, 12'h001};
      m_bus_reqack = vt[i].m_ack; m_bus_respcyc = vt[i].m_rc; m_bus_resp = 64'hFEED;
      m_bus_resptag = 13'h0555;
      c0_bus_respack = vt[i].c_rack; c1_bus_respack = vt[i].c_rack;
      settle();
      chk($sformatf("vec%0d_m_reqcyc", i), m_bus_reqcyc, vt[i].e_mrc);
      chk($sformatf("vec%0d_m_req", i), m_bus_req, vt[i].e_mreq);
      chk($sformatf("vec%0d_m_respack", i), m_bus_respack, vt[i].e_mrack);
      chk($sformatf("vec%0d_c0_reqack", i), c0_bus_reqack, vt[i].e_c0ack);
      chk($sformatf("vec%0d_c1_reqack", i), c1_bus_reqack, vt[i].e_c1ack);
      chk($sformatf("vec%0d_c0_respcyc", i), c0_bus_respcyc, vt[i].e_c0rc);
      chk($sformatf("vec%0d_c1_respcyc", i), c1_bus_respcyc, vt[i].e_c1rc);
      tick();
    end
  endtask

  // ---------------- randomized traffic ----------------
  function automatic logic [63:0] wdata(input logic [63:0] a, input int i);
    return a + 64'hA0 + 64'(i);
  endfunction

  function automatic logic [63:0] rdata(input logic [63:0] a, input int i);
    return ~a ^ (64'h1111 * 64'(i + 1));
  endfunction

  // Model: the bus is either free or owned by one client working through a
  // transaction (phase 0 = address, 1 = write data, 2 = read data, idx =
  // beats done). A free bus is granted to the sole requester, or when both
  // request, to the one that was not granted last.
  task automatic random_test(input int n_trans);
    logic        cl_act[2];
    logic        cl_wr[2];
    logic [63:0] cl_addr[2];
    int          todo[2];
    logic        rc[2];
    logic        rack[2];
    logic [63:0] rq[2];
    logic [12:0] tg[2];
    logic        mack, mrc;
    logic [63:0] mresp;
    logic [12:0] mtag;
    logic        bus_free;
    int          own, lastg, ph, idx, cyc;
    bus_free = 1; own = 0; lastg = 1; ph = 0; idx = 0; cyc = 0;
    for (int n = 0; n < 2; n++) begin
      cl_act[n] = 0; cl_wr[n] = 0; cl_addr[n] = '0; todo[n] = n_trans;
    end
    while ((todo[0] > 0 || todo[1] > 0) && cyc < 20000) begin
      for (int n = 0; n < 2; n++) begin
        if (!cl_act[n] && todo[n] > 0 && $urandom_range(0, 3) == 0) begin
          cl_act[n] = 1;
          cl_wr[n] = 1'($urandom_range(0, 1));
          cl_addr[n] = {32'($urandom), 32'($urandom)} & ~64'h3F;
        end
        rc[n] = 0;
        if (cl_act[n]) begin
          if (bus_free || own != n || ph == 0) rc[n] = 1;
          else if (ph == 1) rc[n] = ($urandom_range(0, 3) != 0);
        end
        rq[n] = (!bus_free && own == n && ph == 1) ? wdata(cl_addr[n], idx) : cl_addr[n];
        tg[n] = {cl_wr[n], 11'h000, 1'(n)};
        rack[n] = 1'($urandom_range(0, 1));
      end
      mack = ($urandom_range(0, 2) != 0);
      if (!bus_free && ph == 2) begin
        mrc = ($urandom_range(0, 2) != 0);
        mresp = rdata(cl_addr[own], idx);
      end else begin
        mrc = ($urandom_range(0, 7) == 0);
        mresp = {32'($urandom), 32'($urandom)};
      end
      mtag = 13'($urandom);
      c0_bus_reqcyc = rc[0]; c0_bus_req = rq[0]; c0_bus_reqtag = tg[0]; c0_bus_respack = rack[0];
      c1_bus_reqcyc = rc[1]; c1_bus_req = rq[1]; c1_bus_reqtag = tg[1]; c1_bus_respack = rack[1];
      m_bus_reqack = mack; m_bus_respcyc = mrc; m_bus_resp = mresp; m_bus_resptag = mtag;
      settle();
      chk("rnd_m_reqcyc", m_bus_reqcyc, (!bus_free && ph < 2) ? rc[own] : 1'b0);
      chk("rnd_c0_reqack", c0_bus_reqack, (!bus_free && ph < 2 && own == 0) ? mack : 1'b0);
      chk("rnd_c1_reqack", c1_bus_reqack, (!bus_free && ph < 2 && own == 1) ? mack : 1'b0);
      chk("rnd_c0_respcyc", c0_bus_respcyc, (!bus_free && ph == 2 && own == 0) ? mrc : 1'b0);
      chk("rnd_c1_respcyc", c1_bus_respcyc, (!bus_free && ph == 2 && own == 1) ? mrc : 1'b0);
      chk("rnd_m_respack", m_bus_respack, (!bus_free && ph == 2) ? rack[own] : 1'b0);
      if (bus_free) chk("rnd_idle_m_req", m_bus_req, 64'h0);
      if (!bus_free && ph < 2 && rc[own]) begin
        chk("rnd_m_req", m_bus_req, (ph == 0) ? cl_addr[own] : wdata(cl_addr[own], idx));
        chk("rnd_m_reqtag", m_bus_reqtag, tg[own]);
      end
      if (!bus_free && ph == 2 && mrc) begin
        chk("rnd_resp", (own == 0) ? c0_bus_resp : c1_bus_resp, rdata(cl_addr[own], idx));
        chk("rnd_resptag", (own == 0) ? c0_bus_resptag : c1_bus_resptag, mtag);
      end
      // advance the model to match the coming edge
      if (bus_free) begin
        if (rc[0] || rc[1]) begin
          own = (rc[0] && rc[1]) ? 1 - lastg : (rc[1] ? 1 : 0);
          lastg = own; bus_free = 0; ph = 0; idx = 0;
        end
      end else if (ph == 0) begin
        if (mack) begin ph = cl_wr[own] ? 1 : 2; idx = 0; end
      end else if ((ph == 1 && rc[own] && mack) || (ph == 2 && mrc && rack[own])) begin
        idx++;
        if (idx == BEATS) begin
          bus_free = 1; cl_act[own] = 0; todo[own]--;
        end
      end
      tick();
      cyc++;
    end
    chk("rnd_all_transactions_done", 64'(todo[0] + todo[1]), 64'h0);
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    do_reset();

    run_table();

    // Single read from c0 at 0x1000 with 3 cycles of respack backpressure.
    do_reset();
    request(0, 64'h1000);
    settle();
    chk("rd1_idle_m_reqcyc", m_bus_reqcyc, 0);
    tick();
    grant_addr(0, 64'h1000);
    read_burst(0, BEATS, 3, 3);
    m_bus_respcyc = 1; c0_bus_respack = 1;
    settle();
    chk("rd1_after_respcyc", c0_bus_respcyc, 0);
    chk("rd1_after_respack", m_bus_respack, 0);
    chk("rd1_after_state", dbg_state, 0);
    tick();
    clear_inputs();

    // Contention: both clients at once after reset; c0, c1, then c0 again.
    do_reset();
    request(0, 64'h100);
    request(1, 64'h200);
    tick();
    grant_addr(0, 64'h100);
    read_burst(0, BEATS, -1, 0);
    settle();
    chk("rr_turnaround_idle", m_bus_reqcyc, 0);
    tick();
    grant_addr(1, 64'h200);
    read_burst(1, BEATS, -1, 0);
    request(0, 64'h100);
    request(1, 64'h200);
    settle();
    chk("rr_round3_idle", m_bus_reqcyc, 0);
    tick();
    grant_addr(0, 64'h100);
    clear_inputs();

    // Reset on the 4th read beat, then a fresh c1 request.
    do_reset();
    request(0, 64'h1000);
    tick();
    grant_addr(0, 64'h1000);
    read_burst(0, 3, -1, 0);
    m_bus_respcyc = 1; m_bus_resp = 64'h44; c0_bus_respack = 1;
    reset = 1;
    tick();
    reset = 0;
    request(1, 64'h5000);
    settle();
    chk_zero("mid_reset");
    tick();
    m_bus_respcyc = 0; c0_bus_respack = 0;
    grant_addr(1, 64'h5000);
    read_burst(1, BEATS, 5, 1);

    // Randomized traffic from both clients.
    do_reset();
    random_test(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
